addsub: RTL and testbench



---
 rtl/addsub_if.sv | 27 ++
 rtl/addsub.sv | 87 ++++++++
 tb/tb_addsub.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/addsub_if.sv
// addsub_if: operand/result bundle for the addsub arithmetic core.
// The master drives the operands and op select and receives the result and flags.
// The slave is the arithmetic core.
interface addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic             cf;
  logic             ovf;
  logic             sf;
  logic             zf;

  modport master (
    output in_valid, a, b, sub,
    input  out_valid, sum, cf, ovf, sf, zf
  );

  modport slave (
    input  in_valid, a, b, sub,
    output out_valid, sum, cf, ovf, sf, zf
  );
endinterface

// File: rtl/addsub.sv
// addsub: two's-complement adder/subtractor with a registered result and ALU flags.
// Latency is one cycle. Subtraction is a + ~b + 1, so a single adder serves both ops.
// The result and all flags come from the same sum, so they always describe one operation.
module addsub #(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst_n,
  addsub_if.slave bus
);

  // Signed overflow: the effective operands share a sign and the result sign differs.
  function automatic logic calc_ovf(input logic a_msb, input logic bb_msb, input logic res_msb);
    calc_ovf = (a_msb == bb_msb) && (res_msb != a_msb);
  endfunction

  // Zero detect on the truncated result.
  function automatic logic is_zero(input logic [WIDTH-1:0] v);
    is_zero = (v == {WIDTH{1'b0}});
  endfunction

  logic [WIDTH-1:0] bb_s;
  logic [WIDTH:0]   res_s;
  logic             cf_s;
  logic             ovf_s;
  logic             sf_s;
  logic             zf_s;

  logic             out_valid_r;
  logic [WIDTH-1:0] sum_r;
  logic             cf_r;
  logic             ovf_r;
  logic             sf_r;
  logic             zf_r;

  // Combinational add/subtract and flag derivation from the current operands.
  always_comb begin
    bb_s  = {WIDTH{1'b0}};
    res_s = {(WIDTH+1){1'b0}};
    if (bus.sub) begin
      bb_s = ~bus.b;
    end else begin
      bb_s = bus.b;
    end
    res_s = {1'b0, bus.a} + {1'b0, bb_s} + {{WIDTH{1'b0}}, bus.sub};
    // Carry out inverted on subtract gives the unsigned borrow (a < b).
    cf_s  = res_s[WIDTH] ^ bus.sub;
    ovf_s = calc_ovf(bus.a[WIDTH-1], bb_s[WIDTH-1], res_s[WIDTH-1]);
    sf_s  = res_s[WIDTH-1];
    zf_s  = is_zero(res_s[WIDTH-1:0]);
  end

  // Output registers: capture a new result on in_valid and hold it otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      sum_r       <= {WIDTH{1'b0}};
      cf_r        <= 1'b0;
      ovf_r       <= 1'b0;
      sf_r        <= 1'b0;
      zf_r        <= 1'b0;
    end else begin
      out_valid_r <= bus.in_valid;
      if (bus.in_valid) begin
        sum_r <= res_s[WIDTH-1:0];
        cf_r  <= cf_s;
        ovf_r <= ovf_s;
        sf_r  <= sf_s;
        zf_r  <= zf_s;
      end else begin
        sum_r <= sum_r;
        cf_r  <= cf_r;
        ovf_r <= ovf_r;
        sf_r  <= sf_r;
        zf_r  <= zf_r;
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.cf        = cf_r;
  assign bus.ovf       = ovf_r;
  assign bus.sf        = sf_r;
  assign bus.zf        = zf_r;

endmodule

// File: tb/tb_addsub.sv
// tb_addsub: directed, table-driven bench for addsub at WIDTH=4.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_addsub;
  localparam int W = 4;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] sum;
    logic         cf;
    logic         ovf;
    logic         sf;
    logic         zf;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  vec_t vecs [9];

  addsub_if #(.WIDTH(W)) bus ();

  addsub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1, "watchdog");
  end

  // Compare the packed {out_valid, sum, cf, ovf, sf, zf} observation.
  task automatic check(input string name, input logic [W+4:0] want);
    logic [W+4:0] got;
    got = {bus.out_valid, bus.sum, bus.cf, bus.ovf, bus.sf, bus.zf};
    n_vec = n_vec + 1;
    if (got !== want) begin
      n_err = n_err + 1;
      $display("FAIL %s: got {v,sum,cf,ovf,sf,zf}=%b want %b", name, got, want);
    end
  endtask

  // Drive one operation on the falling edge.
  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clk);
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.sub      = s;
  endtask

  // Advance to just after the next rising edge.
  task automatic sample_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    //          a        b        sub   sum      cf    ovf   sf    zf
    vecs[0] = '{4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{4'b0011, 4'b0011, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{4'b1011, 4'b0011, 1'b0, 4'b1110, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{4'b1111, 4'b0011, 1'b1, 4'b1100, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{4'b0011, 4'b1111, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{4'b0011, 4'b0011, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{4'b1000, 4'b0111, 1'b1, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b1, 1'b0};

    bus.in_valid = 1'b0;
    bus.a        = 4'b0000;
    bus.b        = 4'b0000;
    bus.sub      = 1'b0;
    rst_n        = 1'b0;

    // Reset state, before and after clock edges while held in reset.
    #1;
    check("reset_initial", {1'b1 & 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0});
    bus.in_valid = 1'b1;
    bus.a        = 4'b1111;
    bus.b        = 4'b1111;
    sample_edge();
    sample_edge();
    check("reset_held", {1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0});
    drive(1'b0, 4'b0000, 4'b0000, 1'b0);
    rst_n = 1'b1;

    // Table vectors applied back-to-back at full rate.
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].sub);
      sample_edge();
      check($sformatf("vec%0d", i),
            {1'b1, vecs[i].sum, vecs[i].cf, vecs[i].ovf, vecs[i].sf, vecs[i].zf});
    end

    // Alternate sub every cycle with fixed operands 0101 and 0011.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 4'b0101, 4'b0011, k[0]);
      sample_edge();
      if (k[0]) begin
        check($sformatf("alt_sub%0d", k), {1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0});
      end else begin
        check($sformatf("alt_add%0d", k), {1'b1, 4'b1000, 1'b0, 1'b1, 1'b1, 1'b0});
      end
    end

    // Drop in_valid with new operands: out_valid falls, result holds 0101-0011.
    drive(1'b0, 4'b1111, 4'b1111, 1'b0);
    sample_edge();
    check("idle_hold1", {1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0});
    sample_edge();
    check("idle_hold2", {1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0});

    // Mid-stream asynchronous reset with another operation in flight.
    drive(1'b1, 4'b0111, 4'b0001, 1'b0);
    sample_edge();
    check("pre_reset", {1'b1, 4'b1000, 1'b0, 1'b1, 1'b1, 1'b0});
    drive(1'b1, 4'b1111, 4'b1111, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0});
    sample_edge();
    check("reset_discard", {1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0});

    // Release with in_valid low, then the first valid after release is what appears.
    drive(1'b0, 4'b1111, 4'b1111, 1'b0);
    rst_n = 1'b1;
    sample_edge();
    check("post_release_idle", {1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0});
    drive(1'b1, 4'b0011, 4'b1111, 1'b1);
    sample_edge();
    check("first_after_reset", {1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0});
    drive(1'b0, 4'b0000, 4'b0000, 1'b0);
    sample_edge();
    check("final_idle", {1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
